// File: rtl/shift_register_univ.sv
// Universal shift register (hold / shift-left / shift-right / load) with word-framing counter.
// Latency: one clk edge from any input to out_o/cnt_o/word_o; all outputs are flop outputs.
// Backpressure: none; en_i=0 freezes state and clears the word strobe.
// Optional rotate support (rot_i port) is enabled by defining SHIFT_REG_ROTATE_EN.
module shift_register_univ #(
  parameter int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic             ser_l_i,
  input  logic             ser_r_i,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic             rot_i,
`endif
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] out_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             word_o
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  // Last count value of a word; the shift that lands on it completes the word.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             word_q, word_d;
  logic             fill_l, fill_r;
  logic             do_shift;

  // Select the incoming bit per direction; rotate recirculates the bit shifted out.
  always_comb begin
    fill_l = ser_l_i;
    fill_r = ser_r_i;
`ifdef SHIFT_REG_ROTATE_EN
    if (rot_i) begin
      fill_l = out_q[WIDTH-1];
      fill_r = out_q[0];
    end
`endif
  end

  // Next-state: data path per mode, then the word counter for any shift.
  always_comb begin
    out_d    = out_q;
    cnt_d    = cnt_q;
    word_d   = 1'b0;
    do_shift = 1'b0;
    if (en_i) begin
      case (mode_i)
        MODE_LEFT: begin
          out_d    = {out_q[WIDTH-2:0], fill_l};
          do_shift = 1'b1;
        end
        MODE_RIGHT: begin
          out_d    = {fill_r, out_q[WIDTH-1:1]};
          do_shift = 1'b1;
        end
        MODE_LOAD: begin
          // A load starts a fresh word; any partial count is dropped.
          out_d = data_i;
          cnt_d = '0;
        end
        MODE_HOLD: ;
        default: ;
      endcase
    end
    if (do_shift) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        word_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset that overrides enable and mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      cnt_q  <= '0;
      word_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign out_o  = out_q;
  assign cnt_o  = cnt_q;
  assign word_o = word_q;

endmodule

// File: tb/tb_shift_register_univ.sv
// Directed bench for shift_register_univ (WIDTH=16) with a queue-based scoreboard.
module tb_shift_register_univ;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en_i = 1'b0;
  logic [1:0]  mode_i = 2'b00;
  logic        ser_l_i = 1'b0;
  logic        ser_r_i = 1'b0;
  logic [15:0] data_i = 16'h0;
`ifdef SHIFT_REG_ROTATE_EN
  logic        rot_i = 1'b0;
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif
  logic [15:0] out_o;
  logic [3:0]  cnt_o;
  logic        word_o;

  int total = 0;
  int bad   = 0;
  int pulses;

  typedef struct packed {
    logic [15:0] o;
    logic [3:0]  c;
    logic        w;
  } exp_t;

  exp_t sb[$];

  // Reference state
  logic [15:0] m_out;
  logic [3:0]  m_cnt;
  logic        m_word;

  shift_register_univ #(.WIDTH(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .en_i   (en_i),
    .mode_i (mode_i),
    .ser_l_i(ser_l_i),
    .ser_r_i(ser_r_i),
`ifdef SHIFT_REG_ROTATE_EN
    .rot_i  (rot_i),
`endif
    .data_i (data_i),
    .out_o  (out_o),
    .cnt_o  (cnt_o),
    .word_o (word_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model, push the expectation, then compare after the edge.
  task automatic step(input logic r, input logic e, input logic [1:0] md,
                      input logic sl, input logic sr, input logic [15:0] d,
                      input logic rt);
    exp_t ex;
    logic use_rot;
    logic sh;
    reset   = r;
    en_i    = e;
    mode_i  = md;
    ser_l_i = sl;
    ser_r_i = sr;
    data_i  = d;
`ifdef SHIFT_REG_ROTATE_EN
    rot_i   = rt;
`endif
    use_rot = rt & ROT_EN;
    sh = 1'b0;
    if (r) begin
      m_out = 16'h0; m_cnt = 4'd0; m_word = 1'b0;
    end else if (!e) begin
      m_word = 1'b0;
    end else begin
      m_word = 1'b0;
      case (md)
        2'b01: begin m_out = {m_out[14:0], use_rot ? m_out[15] : sl}; sh = 1'b1; end
        2'b10: begin m_out = {use_rot ? m_out[0] : sr, m_out[15:1]}; sh = 1'b1; end
        2'b11: begin m_out = d; m_cnt = 4'd0; end
        default: ;
      endcase
      if (sh) begin
        if (m_cnt == 4'd15) begin m_cnt = 4'd0; m_word = 1'b1; end
        else m_cnt = m_cnt + 4'd1;
      end
    end
    ex.o = m_out; ex.c = m_cnt; ex.w = m_word;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    ex = sb.pop_front();
    chk("out_o",  {16'h0, out_o},  {16'h0, ex.o});
    chk("cnt_o",  {28'h0, cnt_o},  {28'h0, ex.c});
    chk("word_o", {31'h0, word_o}, {31'h0, ex.w});
    if (word_o) pulses++;
  endtask

  task automatic shifts(input int n, input logic [1:0] md, input logic bit_in);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, md, bit_in, bit_in, 16'h0, 1'b0);
  endtask

  initial begin
    m_out = 16'h0; m_cnt = 4'd0; m_word = 1'b0;
    pulses = 0;
    #2;

    // 1: reset with random inputs, then an idle edge
    step(1'b1, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom));
    chk("reset_out", {16'h0, out_o}, 32'h0);
    chk("reset_cnt", {28'h0, cnt_o}, 32'h0);
    step(1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 16'hFFFF, 1'b0);
    chk("idle_out", {16'h0, out_o}, 32'h0);

    // 2: load then 4 shift-left of ones
    step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 16'hA5C3, 1'b0);
    shifts(4, 2'b01, 1'b1);
    chk("sl4_out", {16'h0, out_o}, 32'h5C3F);
    chk("sl4_cnt", {28'h0, cnt_o}, 32'd4);

    // 3: full words of shift-right from reset
    step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0, 1'b0);
    pulses = 0;
    shifts(15, 2'b10, 1'b1);
    chk("sr15_nopulse", pulses, 0);
    shifts(1, 2'b10, 1'b1);
    chk("sr16_out", {16'h0, out_o}, 32'hFFFF);
    chk("sr16_word", {31'h0, word_o}, 32'h1);
    chk("sr16_cnt", {28'h0, cnt_o}, 32'h0);
    shifts(1, 2'b10, 1'b1);
    chk("sr17_word", {31'h0, word_o}, 32'h0);
    shifts(15, 2'b10, 1'b1);
    chk("sr32_word", {31'h0, word_o}, 32'h1);
    chk("sr32_pulses", pulses, 2);

    // 4: disabled shift and hold keep the loaded value
    step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 16'h1234, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 16'h0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 16'h0, 1'b0);
    chk("hold_out", {16'h0, out_o}, 32'h1234);
    chk("hold_cnt", {28'h0, cnt_o}, 32'h0);

    // 5a: reset mid-word
    shifts(7, 2'b01, 1'b1);
    pulses = 0;
    step(1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 16'h0, 1'b0);
    chk("abort_rst_out", {16'h0, out_o}, 32'h0);
    chk("abort_rst_cnt", {28'h0, cnt_o}, 32'h0);
    shifts(15, 2'b01, 1'b0);
    chk("abort_rst_15", pulses, 0);
    shifts(1, 2'b01, 1'b0);
    chk("abort_rst_16", {31'h0, word_o}, 32'h1);

    // 5b: load mid-word, mixed directions
    shifts(4, 2'b01, 1'b1);
    shifts(3, 2'b10, 1'b0);
    pulses = 0;
    step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 16'hBEEF, 1'b0);
    chk("abort_ld_cnt", {28'h0, cnt_o}, 32'h0);
    chk("abort_ld_word", {31'h0, word_o}, 32'h0);
    shifts(8, 2'b10, 1'b1);
    shifts(7, 2'b01, 1'b0);
    chk("abort_ld_15", pulses, 0);
    shifts(1, 2'b10, 1'b0);
    chk("abort_ld_16", pulses, 1);

    // Random mix against the model
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), 2'($urandom),
           1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom));

`ifdef SHIFT_REG_ROTATE_EN
    // 6: rotate
    step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 16'h8001, 1'b0);
    step(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("rotl_out", {16'h0, out_o}, 32'h0003);
    step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 16'h8001, 1'b1);
    step(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("rotr_out", {16'h0, out_o}, 32'hC000);
    step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 16'h8001, 1'b0);
    pulses = 0;
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("rot16_out", {16'h0, out_o}, 32'h8001);
    chk("rot16_pulses", pulses, 1);
    chk("rot16_word", {31'h0, word_o}, 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
